// File: rtl/masked_share_bundler.sv
// masked_share_bundler: pairs share-major masked data with fresh randomness and emits registered bit-major bundles
module masked_share_bundler #(
  parameter int WIDTH      = 8,
  parameter int SHARES     = 2,
  parameter int RAND_W     = 28,
  parameter int RAND_DEPTH = 2,
  parameter int CNT_W      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic [SHARES*WIDTH-1:0]   in_shares_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [RAND_W-1:0]         prd_i,
  input  logic                      prd_valid_i,
  output logic                      prd_ready_o,
  output logic [WIDTH*SHARES-1:0]   out_bundle_o,
  output logic [RAND_W-1:0]         out_prd_o,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CNT_W-1:0]          beat_cnt_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);
  localparam int DW = SHARES * WIDTH;
  localparam int AW = $clog2(RAND_DEPTH);
  logic [DW-1:0]     dbuf [2];
  logic [1:0]        dcnt, dcnt_nx;
  logic [RAND_W-1:0] rbuf [RAND_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       rcnt, rcnt_nx;
  logic              push_d, push_r, fire;
  logic [DW-1:0]     regroup;
  assign push_d  = in_valid_i && in_ready_o && !flush_i;
  assign push_r  = prd_valid_i && prd_ready_o && !flush_i;
  assign fire    = dcnt != 2'd0 && rcnt != '0 && (!out_valid_o || out_ready_i) && !flush_i;
  assign dcnt_nx = flush_i ? 2'd0 : dcnt + 2'(push_d) - 2'(fire);
  assign rcnt_nx = flush_i ? '0 : rcnt + (AW+1)'(push_r) - (AW+1)'(fire);
  // Pure wiring from the oldest entry: shares are only moved, never combined.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    for (genvar s = 0; s < SHARES; s++) begin : g_share
      assign regroup[b*SHARES+s] = dbuf[0][s*WIDTH+b];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dcnt         <= '0;
      rcnt         <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      in_ready_o   <= 1'b0;
      prd_ready_o  <= 1'b0;
      out_valid_o  <= 1'b0;
      out_bundle_o <= '0;
      out_prd_o    <= '0;
      beat_cnt_o   <= '0;
      stall_cnt_o  <= '0;
    end else begin
      dcnt        <= dcnt_nx;
      rcnt        <= rcnt_nx;
      in_ready_o  <= dcnt_nx != 2'd2;
      prd_ready_o <= rcnt_nx != (AW+1)'(RAND_DEPTH);
      if (out_valid_o && out_ready_i) beat_cnt_o <= beat_cnt_o + CNT_W'(1);
      if (dcnt != 2'd0 && rcnt == '0 && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_i) begin
        out_valid_o <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
      end else begin
        if (fire) dbuf[0] <= dbuf[1];
        // A push lands behind the surviving entry; it overrides the shift when the buffer drains to empty.
        if (push_d) dbuf[dcnt[0] & !fire] <= in_shares_i;
        if (push_r) begin
          rbuf[wr_ptr] <= prd_i;
          wr_ptr       <= wr_ptr + AW'(1);
        end
        if (fire) begin
          rd_ptr       <= rd_ptr + AW'(1);
          out_bundle_o <= regroup;
          out_prd_o    <= rbuf[rd_ptr];
          out_valid_o  <= 1'b1;
        end else if (out_ready_i) out_valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_masked_share_bundler.sv
// tb_masked_share_bundler: directed checks on a default instance and a narrow-counter, three-share instance
module tb_masked_share_bundler;
  logic clk = 0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic rst, flush_a, in_valid_a, in_ready_a, prd_valid_a, prd_ready_a, ov_a, ordy_a;
  logic [15:0] in_a, bundle_a;
  logic [27:0] prd_a, oprd_a;
  logic [7:0] beat_a, stall_a;

  logic rst_b, flush_b, in_valid_b, in_ready_b, prd_valid_b, prd_ready_b, ov_b, ordy_b;
  logic [11:0] in_b, bundle_b;
  logic [7:0] prd_b, oprd_b;
  logic [2:0] beat_b, stall_b;

  masked_share_bundler dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush_a),
    .in_shares_i(in_a), .in_valid_i(in_valid_a), .in_ready_o(in_ready_a),
    .prd_i(prd_a), .prd_valid_i(prd_valid_a), .prd_ready_o(prd_ready_a),
    .out_bundle_o(bundle_a), .out_prd_o(oprd_a), .out_valid_o(ov_a), .out_ready_i(ordy_a),
    .beat_cnt_o(beat_a), .stall_cnt_o(stall_a));

  masked_share_bundler #(.WIDTH(4), .SHARES(3), .RAND_W(8), .RAND_DEPTH(2), .CNT_W(3)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .flush_i(flush_b),
    .in_shares_i(in_b), .in_valid_i(in_valid_b), .in_ready_o(in_ready_b),
    .prd_i(prd_b), .prd_valid_i(prd_valid_b), .prd_ready_o(prd_ready_b),
    .out_bundle_o(bundle_b), .out_prd_o(oprd_b), .out_valid_o(ov_b), .out_ready_i(ordy_b),
    .beat_cnt_o(beat_b), .stall_cnt_o(stall_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rg_a(input logic [15:0] d);
    logic [15:0] r;
    for (int b = 0; b < 8; b++) for (int s = 0; s < 2; s++) r[b*2+s] = d[s*8+b];
    return r;
  endfunction

  function automatic logic [11:0] rg_b(input logic [11:0] d);
    logic [11:0] r;
    for (int b = 0; b < 4; b++) for (int s = 0; s < 3; s++) r[b*3+s] = d[s*4+b];
    return r;
  endfunction

  // Scoreboard for instance b: handshakes seen at the falling edge complete on the next rising edge.
  logic [11:0] dq[$];
  logic [7:0]  rq[$];
  always @(negedge clk) begin
    if (rst_b || flush_b) begin
      dq.delete();
      rq.delete();
    end else begin
      if (ov_b && ordy_b) begin
        chk("b_sb_nonempty", 64'(dq.size() > 0 && rq.size() > 0), 64'd1);
        if (dq.size() > 0 && rq.size() > 0) begin
          chk("b_bundle", 64'(bundle_b), 64'(rg_b(dq.pop_front())));
          chk("b_prd", 64'(oprd_b), 64'(rq.pop_front()));
        end
      end
      if (in_valid_b && in_ready_b) dq.push_back(in_b);
      if (prd_valid_b && prd_ready_b) rq.push_back(prd_b);
    end
  end

  initial begin
    logic [15:0] d1, d2, d4, d5, d6;
    rst = 1; flush_a = 0; in_valid_a = 0; prd_valid_a = 0; ordy_a = 1; in_a = '0; prd_a = '0;
    rst_b = 1; flush_b = 0; in_valid_b = 0; prd_valid_b = 0; ordy_b = 1; in_b = '0; prd_b = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_prd_ready", prd_ready_a, 0);
    chk("rst_valid", ov_a, 0);
    chk("rst_bundle", bundle_a, 0);
    chk("rst_prd", oprd_a, 0);
    chk("rst_beat", beat_a, 0);
    chk("rst_stall", stall_a, 0);
    rst = 0; rst_b = 0;
    tick();
    chk("post_rst_in_ready", in_ready_a, 1);
    chk("post_rst_prd_ready", prd_ready_a, 1);

    // Single beat: s0=A5, s1=3C
    in_a = {8'h3C, 8'hA5}; in_valid_a = 1; prd_a = 28'h1; prd_valid_a = 1;
    tick();
    in_valid_a = 0; prd_valid_a = 0;
    tick();
    chk("t1_valid", ov_a, 1);
    chk("t1_bundle", bundle_a, 16'h4EB1);
    chk("t1_prd", oprd_a, 28'h1);
    tick();
    chk("t1_beat", beat_a, 1);
    chk("t1_valid_drop", ov_a, 0);

    // Data without randomness
    d1 = 16'h1234; d2 = 16'hBEEF;
    in_a = d1; in_valid_a = 1; tick();
    in_a = d2; tick();
    in_a = 16'h0F0F; tick();
    chk("t2_in_ready_full", in_ready_a, 0);
    chk("t2_stall2", stall_a, 2);
    in_valid_a = 0;
    tick(); tick();
    chk("t2_stall4", stall_a, 4);
    chk("t2_no_valid", ov_a, 0);
    prd_a = 28'h1; prd_valid_a = 1; tick();
    prd_a = 28'h2; tick();
    prd_valid_a = 0;
    chk("t2_o1_valid", ov_a, 1);
    chk("t2_o1_prd", oprd_a, 28'h1);
    chk("t2_o1_bundle", bundle_a, rg_a(d1));
    chk("t2_stall5", stall_a, 5);
    tick();
    chk("t2_o2_prd", oprd_a, 28'h2);
    chk("t2_o2_bundle", bundle_a, rg_a(d2));
    tick();
    chk("t2_idle", ov_a, 0);
    chk("t2_beat", beat_a, 3);
    chk("t2_in_ready_back", in_ready_a, 1);

    // Backpressure
    ordy_a = 0; d4 = 16'hC3A5; d5 = 16'h5A96;
    in_a = d4; in_valid_a = 1; prd_a = 28'h3; prd_valid_a = 1; tick();
    in_a = d5; prd_a = 28'h4; tick();
    in_valid_a = 0; prd_valid_a = 0;
    chk("t3_valid", ov_a, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_bundle", bundle_a, rg_a(d4));
      chk("t3_hold_prd", oprd_a, 28'h3);
      chk("t3_hold_beat", beat_a, 3);
    end
    ordy_a = 1; tick();
    chk("t3_b2b_valid", ov_a, 1);
    chk("t3_b2b_prd", oprd_a, 28'h4);
    chk("t3_b2b_bundle", bundle_a, rg_a(d5));
    chk("t3_b2b_beat", beat_a, 4);
    tick();
    chk("t3_drain", ov_a, 0);
    chk("t3_beat", beat_a, 5);

    // Flush with a full randomness FIFO
    prd_a = 28'h5; prd_valid_a = 1; tick();
    prd_a = 28'h6; tick();
    prd_valid_a = 0;
    chk("t4_prd_full", prd_ready_a, 0);
    flush_a = 1; tick(); flush_a = 0;
    chk("t4_valid", ov_a, 0);
    chk("t4_in_ready", in_ready_a, 1);
    chk("t4_prd_ready", prd_ready_a, 1);
    chk("t4_beat", beat_a, 5);
    d6 = 16'h7E81;
    in_a = d6; in_valid_a = 1; tick();
    in_valid_a = 0; tick();
    chk("t4_waits", ov_a, 0);
    prd_a = 28'h7; prd_valid_a = 1; tick();
    prd_valid_a = 0; tick();
    chk("t4_new_valid", ov_a, 1);
    chk("t4_new_prd", oprd_a, 28'h7);
    chk("t4_new_bundle", bundle_a, rg_a(d6));
    tick();
    chk("t4_beat_after", beat_a, 6);

    // Instance b: counter wrap
    in_valid_b = 1; prd_valid_b = 1; ordy_b = 1;
    for (int i = 0; i < 9; i++) begin
      in_b = 12'($urandom); prd_b = 8'($urandom);
      tick();
    end
    in_valid_b = 0; prd_valid_b = 0;
    repeat (4) tick();
    chk("b_beat_wrap", beat_b, 1);
    chk("b_idle", ov_b, 0);
    // Starvation saturates the stall counter
    in_b = 12'hA5C; in_valid_b = 1; tick();
    in_valid_b = 0;
    repeat (10) tick();
    chk("b_stall_sat", stall_b, 7);
    chk("b_starved", ov_b, 0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      in_b = 12'($urandom); prd_b = 8'($urandom);
      in_valid_b = 1'($urandom); prd_valid_b = 1'($urandom); ordy_b = 1'($urandom);
      tick();
    end
    in_valid_b = 1; prd_valid_b = 1; ordy_b = 0;
    tick(); tick();
    rst_b = 1; tick();
    chk("b_rst_valid", ov_b, 0);
    chk("b_rst_bundle", bundle_b, 0);
    chk("b_rst_prd", oprd_b, 0);
    chk("b_rst_beat", beat_b, 0);
    chk("b_rst_stall", stall_b, 0);
    chk("b_rst_in_ready", in_ready_b, 0);
    rst_b = 0; in_valid_b = 0; prd_valid_b = 0; ordy_b = 1;
    tick();
    chk("b_post_rst_ready", in_ready_b, 1);
    chk("b_post_rst_valid", ov_b, 0);
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
